// File: rtl/mt_register_file_gen2_if.sv
// Register-file access bundle: writeback port, N read ports, per-thread clear control and status.
interface mt_register_file_gen2_if #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_THREADS    = 4,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned NUM_READ_PORTS = 2
);
  localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int unsigned RA_W  = $clog2(NUM_REGS);

  logic                             wr_en;
  logic [TID_W-1:0]                 wr_thread;
  logic [RA_W-1:0]                  wr_addr;
  logic [XLEN-1:0]                  wr_data;
  logic                             wr_ready;
  logic [NUM_READ_PORTS-1:0]        rd_en;
  logic [NUM_READ_PORTS*TID_W-1:0]  rd_thread;
  logic [NUM_READ_PORTS*RA_W-1:0]   rd_addr;
  logic [NUM_READ_PORTS*XLEN-1:0]   rd_data;
  logic                             clr_req;
  logic [TID_W-1:0]                 clr_thread;
  logic                             busy;
  logic                             clr_done;

  modport master (
    output wr_en, wr_thread, wr_addr, wr_data, rd_en, rd_thread, rd_addr, clr_req, clr_thread,
    input  wr_ready, rd_data, busy, clr_done
  );

  modport slave (
    input  wr_en, wr_thread, wr_addr, wr_data, rd_en, rd_thread, rd_addr, clr_req, clr_thread,
    output wr_ready, rd_data, busy, clr_done
  );
endinterface

// File: rtl/mt_register_file_gen2.sv
// Multithreaded register file: one bank per thread, N registered read ports, hardwired r0,
// write->read bypass option, and a sweep FSM that zeroes storage after reset or per thread on request.
module mt_register_file_gen2 #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned NUM_THREADS    = 4,
  parameter int unsigned NUM_REGS       = 32,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned BYPASS         = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  mt_register_file_gen2_if.slave bus
);
  localparam int unsigned TID_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int unsigned RA_W  = $clog2(NUM_REGS);
  localparam int unsigned DEPTH = NUM_THREADS * NUM_REGS;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR, ST_DONE} state_t;

  state_t                     state;
  logic [IDX_W-1:0]           ctr;
  logic [TID_W-1:0]           clr_thread_q;
  logic                       busy_q;
  logic                       wr_ready_q;
  logic                       clr_done_q;
  logic [NUM_READ_PORTS*XLEN-1:0] rd_q;

  logic [XLEN-1:0]            mem [DEPTH];
  logic                       sweep_we;
  logic [IDX_W-1:0]           sweep_idx;
  logic                       wr_fire;
  logic [XLEN-1:0]            rd_val [NUM_READ_PORTS];

  // Sweep target and accepted-write qualification
  always_comb begin
    sweep_we  = (state == ST_INIT) || (state == ST_CLEAR);
    sweep_idx = ctr;
    if (state == ST_CLEAR) begin
      sweep_idx = IDX_W'({clr_thread_q, ctr[RA_W-1:0]});
    end
    wr_fire = bus.wr_en && wr_ready_q && (bus.wr_addr != '0);
  end

  // Storage has no reset so it can map onto block RAM; the sweep owns the port while busy
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_idx] <= '0;
    end else if (wr_fire) begin
      mem[IDX_W'({bus.wr_thread, bus.wr_addr})] <= bus.wr_data;
    end
  end

  // Sweep FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      ctr          <= '0;
      clr_thread_q <= '0;
      busy_q       <= 1'b1;
      wr_ready_q   <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state)
        ST_INIT: begin
          if (ctr == IDX_W'(DEPTH - 1)) begin
            state      <= ST_DONE;
            ctr        <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
            clr_done_q <= 1'b1;
          end else begin
            ctr <= ctr + IDX_W'(1);
          end
        end
        ST_IDLE: begin
          if (bus.clr_req) begin
            state        <= ST_CLEAR;
            clr_thread_q <= bus.clr_thread;
            ctr          <= IDX_W'(1);
            busy_q       <= 1'b1;
            wr_ready_q   <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (ctr[RA_W-1:0] == RA_W'(NUM_REGS - 1)) begin
            state      <= ST_DONE;
            ctr        <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
            clr_done_q <= 1'b1;
          end else begin
            ctr <= ctr + IDX_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state      <= ST_INIT;
          ctr        <= '0;
          busy_q     <= 1'b1;
          wr_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-port read value: r0 and banks being swept read as zero; optional same-cycle forwarding
  always_comb begin
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      if ((bus.rd_addr[p*RA_W +: RA_W] == '0) || (state == ST_INIT) ||
          ((state == ST_CLEAR) && (bus.rd_thread[p*TID_W +: TID_W] == clr_thread_q))) begin
        rd_val[p] = '0;
      end else if ((BYPASS != 0) && wr_fire &&
                   (bus.rd_thread[p*TID_W +: TID_W] == bus.wr_thread) &&
                   (bus.rd_addr[p*RA_W +: RA_W] == bus.wr_addr)) begin
        rd_val[p] = bus.wr_data;
      end else begin
        rd_val[p] = mem[IDX_W'({bus.rd_thread[p*TID_W +: TID_W], bus.rd_addr[p*RA_W +: RA_W]})];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        if (bus.rd_en[p]) begin
          rd_q[p*XLEN +: XLEN] <= rd_val[p];
        end
      end
    end
  end

  assign bus.rd_data  = rd_q;
  assign bus.busy     = busy_q;
  assign bus.wr_ready = wr_ready_q;
  assign bus.clr_done = clr_done_q;
endmodule

// File: tb/tb_mt_register_file_gen2.sv
// Bench for mt_register_file_gen2: bypass and non-bypass instances share one stimulus stream and
// are checked against an array model; a small 1-thread/16-reg/3-port instance is checked separately.
module tb_mt_register_file_gen2;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NT = 4, NR = 32, NRP = 2, TID_W = 2, RA_W = 5;
  localparam int unsigned S_NR = 16, S_NRP = 3, S_RA_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_n_s = 1'b0;
  always #5 clk = ~clk;

  mt_register_file_gen2_if #(.XLEN(XLEN), .NUM_THREADS(NT), .NUM_REGS(NR), .NUM_READ_PORTS(NRP)) bus0 ();
  mt_register_file_gen2_if #(.XLEN(XLEN), .NUM_THREADS(NT), .NUM_REGS(NR), .NUM_READ_PORTS(NRP)) bus1 ();
  mt_register_file_gen2_if #(.XLEN(XLEN), .NUM_THREADS(1), .NUM_REGS(S_NR), .NUM_READ_PORTS(S_NRP)) bus2 ();

  mt_register_file_gen2 #(.XLEN(XLEN), .NUM_THREADS(NT), .NUM_REGS(NR), .NUM_READ_PORTS(NRP), .BYPASS(1))
    u_byp (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mt_register_file_gen2 #(.XLEN(XLEN), .NUM_THREADS(NT), .NUM_REGS(NR), .NUM_READ_PORTS(NRP), .BYPASS(0))
    u_nobyp (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mt_register_file_gen2 #(.XLEN(XLEN), .NUM_THREADS(1), .NUM_REGS(S_NR), .NUM_READ_PORTS(S_NRP), .BYPASS(1))
    u_small (.clk(clk), .rst_n(rst_n_s), .bus(bus2));

  assign bus1.wr_en      = bus0.wr_en;
  assign bus1.wr_thread  = bus0.wr_thread;
  assign bus1.wr_addr    = bus0.wr_addr;
  assign bus1.wr_data    = bus0.wr_data;
  assign bus1.rd_en      = bus0.rd_en;
  assign bus1.rd_thread  = bus0.rd_thread;
  assign bus1.rd_addr    = bus0.rd_addr;
  assign bus1.clr_req    = bus0.clr_req;
  assign bus1.clr_thread = bus0.clr_thread;

  int total = 0;
  int bad = 0;

  // Reference model: plain 2-D array plus the last value each port returned
  logic [XLEN-1:0] mm [NT][NR];
  logic [XLEN-1:0] hold_b [NRP];
  logic [XLEN-1:0] hold_n [NRP];
  bit mdl_ready;
  bit mask_all;
  int mask_thr;
  logic [XLEN-1:0] sm [S_NR];

  typedef struct {
    bit we; int wt; int wa; logic [XLEN-1:0] wd;
    bit [NRP-1:0] re; int t0; int a0; int t1; int a1;
    logic [XLEN-1:0] eb0; logic [XLEN-1:0] eb1; logic [XLEN-1:0] en0; logic [XLEN-1:0] en1;
  } vec_t;
  vec_t vt [7];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic model_zero();
    for (int t = 0; t < int'(NT); t++)
      for (int a = 0; a < int'(NR); a++) mm[t][a] = '0;
  endtask

  task automatic set_rd(input int p, input int t, input int a);
    bus0.rd_thread[p*TID_W +: TID_W] = TID_W'(t);
    bus0.rd_addr[p*RA_W +: RA_W]     = RA_W'(a);
  endtask

  // One clock of whatever is on bus0; expected read data comes from the model
  task automatic apply_cycle();
    int t, a, wt, wa;
    bit fire;
    wt = int'(bus0.wr_thread);
    wa = int'(bus0.wr_addr);
    fire = bus0.wr_en && mdl_ready && (wa != 0);
    for (int p = 0; p < int'(NRP); p++) begin
      if (bus0.rd_en[p]) begin
        t = int'(bus0.rd_thread[p*TID_W +: TID_W]);
        a = int'(bus0.rd_addr[p*RA_W +: RA_W]);
        if (a == 0 || mask_all || t == mask_thr) begin
          hold_b[p] = '0;
          hold_n[p] = '0;
        end else begin
          hold_n[p] = mm[t][a];
          hold_b[p] = (fire && wt == t && wa == a) ? bus0.wr_data : mm[t][a];
        end
      end
    end
    if (fire) mm[wt][wa] = bus0.wr_data;
    @(posedge clk);
    #1;
    for (int p = 0; p < int'(NRP); p++) begin
      check($sformatf("byp_rd%0d", p), bus0.rd_data[p*XLEN +: XLEN], hold_b[p]);
      check($sformatf("nobyp_rd%0d", p), bus1.rd_data[p*XLEN +: XLEN], hold_n[p]);
    end
  endtask

  task automatic idle_inputs();
    bus0.wr_en = 1'b0; bus0.rd_en = '0; bus0.clr_req = 1'b0;
  endtask

  task automatic read_all();
    idle_inputs();
    bus0.rd_en = 2'b11;
    for (int e = 0; e < int'(NT*NR); e += 2) begin
      set_rd(0, e / int'(NR), e % int'(NR));
      set_rd(1, (e + 1) / int'(NR), (e + 1) % int'(NR));
      apply_cycle();
    end
    bus0.rd_en = '0;
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus0.busy === 1'b1 && n < 1000);
    check({name, "_len"}, XLEN'(n), XLEN'(NT*NR));
    check({name, "_done"}, XLEN'(bus0.clr_done), 1);
    check({name, "_done_nb"}, XLEN'(bus1.clr_done), 1);
    check({name, "_ready"}, XLEN'(bus0.wr_ready), 1);
    model_zero();
    mask_all = 1'b0;
    mdl_ready = 1'b1;
    @(posedge clk);
    #1;
    check({name, "_done_pulse"}, XLEN'(bus0.clr_done), 0);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_busy"}, XLEN'(bus0.busy), 1);
    check({name, "_ready"}, XLEN'(bus0.wr_ready), 0);
    check({name, "_done"}, XLEN'(bus0.clr_done), 0);
    check({name, "_rd0"}, bus0.rd_data[0 +: XLEN], 0);
    check({name, "_rd1"}, bus0.rd_data[XLEN +: XLEN], 0);
    check({name, "_rd1_nb"}, bus1.rd_data[XLEN +: XLEN], 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus0.wr_en = 0; bus0.wr_thread = '0; bus0.wr_addr = '0; bus0.wr_data = '0;
    bus0.rd_en = '0; bus0.rd_thread = '0; bus0.rd_addr = '0; bus0.clr_req = 0; bus0.clr_thread = '0;
    bus2.wr_en = 0; bus2.wr_thread = '0; bus2.wr_addr = '0; bus2.wr_data = '0;
    bus2.rd_en = '0; bus2.rd_thread = '0; bus2.rd_addr = '0; bus2.clr_req = 0; bus2.clr_thread = '0;
    mdl_ready = 0; mask_all = 1; mask_thr = -1;
    for (int p = 0; p < int'(NRP); p++) begin hold_b[p] = '0; hold_n[p] = '0; end

    vt[0] = '{1, 2, 5, 32'hDEADBEEF, 2'b00, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
    vt[1] = '{0, 0, 0, 32'h0, 2'b11, 2, 5, 1, 5, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    vt[2] = '{1, 0, 0, 32'h1234, 2'b11, 0, 0, 2, 5, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vt[3] = '{0, 0, 0, 32'h0, 2'b01, 0, 0, 0, 0, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vt[4] = '{1, 3, 7, 32'h11, 2'b00, 0, 0, 0, 0, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vt[5] = '{1, 3, 7, 32'hA5A5A5A5, 2'b11, 3, 7, 3, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11, 32'h11};
    vt[6] = '{0, 0, 0, 32'h0, 2'b01, 3, 7, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11};

    // Reset state, then full init sweep
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst_n = 1'b1;
    wait_init("init");
    read_all();

    // Directed write/read/bypass vectors
    foreach (vt[i]) begin
      bus0.wr_en = vt[i].we; bus0.wr_thread = TID_W'(vt[i].wt);
      bus0.wr_addr = RA_W'(vt[i].wa); bus0.wr_data = vt[i].wd;
      bus0.rd_en = vt[i].re;
      set_rd(0, vt[i].t0, vt[i].a0);
      set_rd(1, vt[i].t1, vt[i].a1);
      apply_cycle();
      check($sformatf("vec%0d_b0", i), bus0.rd_data[0 +: XLEN], vt[i].eb0);
      check($sformatf("vec%0d_b1", i), bus0.rd_data[XLEN +: XLEN], vt[i].eb1);
      check($sformatf("vec%0d_n0", i), bus1.rd_data[0 +: XLEN], vt[i].en0);
      check($sformatf("vec%0d_n1", i), bus1.rd_data[XLEN +: XLEN], vt[i].en1);
    end

    // Random traffic biased towards address collisions
    for (int i = 0; i < 400; i++) begin
      bus0.wr_en = 1'($urandom_range(0, 1));
      bus0.wr_thread = TID_W'($urandom_range(0, NT - 1));
      bus0.wr_addr = RA_W'($urandom_range(0, 7));
      bus0.wr_data = $urandom();
      bus0.rd_en = NRP'($urandom_range(0, 3));
      for (int p = 0; p < int'(NRP); p++) begin
        if ($urandom_range(0, 1) == 1) set_rd(p, int'(bus0.wr_thread), int'(bus0.wr_addr));
        else set_rd(p, int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 7)));
      end
      apply_cycle();
    end

    // Per-thread clear of t1 with writes and a second clear request arriving mid-sweep
    idle_inputs();
    bus0.wr_en = 1'b1;
    bus0.wr_thread = 1;
    for (int r = 1; r < int'(NR); r++) begin
      bus0.wr_addr = RA_W'(r);
      bus0.wr_data = 32'h1000_0000 | 32'(r);
      apply_cycle();
    end
    bus0.wr_thread = 0; bus0.wr_addr = 31; bus0.wr_data = 32'h0F0F0F0F; apply_cycle();
    bus0.wr_thread = 3; bus0.wr_addr = 20; bus0.wr_data = 32'h3333_0020; apply_cycle();
    idle_inputs();
    bus0.clr_req = 1'b1; bus0.clr_thread = 1;
    apply_cycle();
    check("clr_busy", XLEN'(bus0.busy), 1);
    check("clr_ready", XLEN'(bus0.wr_ready), 0);
    mdl_ready = 1'b0;
    mask_thr = 1;
    n = 1;
    bus0.clr_thread = 2;
    bus0.wr_en = 1'b1; bus0.wr_thread = 1; bus0.wr_addr = 3; bus0.wr_data = 32'hBAD0BAD0;
    bus0.rd_en = 2'b11;
    set_rd(0, 1, 4);
    for (int i = 0; i < 100; i++) begin
      if (i == 3) begin bus0.clr_req = 1'b0; bus0.wr_en = 1'b0; end
      set_rd(1, 2, i % 8);
      apply_cycle();
      if (bus0.busy !== 1'b1) break;
      n++;
    end
    check("clr_len", XLEN'(n), XLEN'(NR - 1));
    check("clr_done", XLEN'(bus0.clr_done), 1);
    check("clr_ready_after", XLEN'(bus0.wr_ready), 1);
    for (int a = 0; a < int'(NR); a++) mm[1][a] = '0;
    mask_thr = -1;
    mdl_ready = 1'b1;
    idle_inputs();
    bus0.clr_req = 1'b1; bus0.clr_thread = 0;
    apply_cycle();
    check("done_ignore_busy", XLEN'(bus0.busy), 0);
    check("done_pulse_end", XLEN'(bus0.clr_done), 0);
    bus0.clr_req = 1'b0;
    apply_cycle();
    check("done_ignore_idle", XLEN'(bus0.busy), 0);
    read_all();

    // Reset asserted while a clear is at ctr=10
    idle_inputs();
    bus0.wr_en = 1'b1; bus0.wr_thread = 3; bus0.wr_addr = 6; bus0.wr_data = 32'hCAFE0001;
    apply_cycle();
    idle_inputs();
    bus0.clr_req = 1'b1; bus0.clr_thread = 2;
    bus0.rd_en = 2'b11; set_rd(0, 3, 6); set_rd(1, 3, 6);
    apply_cycle();
    check("pre_rst_rd", bus0.rd_data[0 +: XLEN], 32'hCAFE0001);
    idle_inputs();
    mdl_ready = 1'b0;
    mask_thr = 2;
    repeat (9) apply_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    mask_all = 1'b1; mask_thr = -1;
    for (int p = 0; p < int'(NRP); p++) begin hold_b[p] = '0; hold_n[p] = '0; end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_init("reinit");
    read_all();

    // Small configuration: 1 thread, 16 regs, 3 ports
    rst_n_s = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (bus2.busy === 1'b1 && n < 1000);
    check("s_init_len", XLEN'(n), XLEN'(S_NR));
    check("s_init_done", XLEN'(bus2.clr_done), 1);
    sm[0] = '0;
    bus2.wr_en = 1'b1;
    for (int r = 1; r < int'(S_NR); r++) begin
      bus2.wr_addr = S_RA_W'(r);
      bus2.wr_data = 32'h5000_0000 + 32'(r * r);
      sm[r] = bus2.wr_data;
      @(posedge clk);
      #1;
    end
    bus2.wr_en = 1'b0;
    bus2.rd_en = 3'b111;
    for (int v = 0; v < 4; v++) begin
      int ad [3];
      for (int p = 0; p < int'(S_NRP); p++) begin
        ad[p] = (v == 0) ? 3 + 6 * p : (v == 1) ? 14 * p % 15 : int'($urandom_range(0, S_NR - 1));
        bus2.rd_addr[p*S_RA_W +: S_RA_W] = S_RA_W'(ad[p]);
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < int'(S_NRP); p++)
        check($sformatf("s_rd%0d_v%0d", p, v), bus2.rd_data[p*XLEN +: XLEN], sm[ad[p]]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
